// File: rtl/mic_freq_meter.sv
// rtl/mic_freq_meter.sv - gated edge-count frequency meter for the mic comparator input
module mic_freq_meter #(
   parameter int CLK_FREQ    = 100_000_000,
   parameter int GATE_CYCLES = 10_000_000,
   parameter int OUT_W       = 16,
   parameter int SYNC_STAGES = 2,
   parameter int AVG_LOG2    = 0,
   parameter int MIN_EDGES   = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic             signal,
   output logic [OUT_W-1:0] freq,
   output logic             freq_valid,
   output logic             silent,
   output logic             overflow
);

   localparam int SCALE = CLK_FREQ / GATE_CYCLES;
   localparam int GW    = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
   localparam int EW    = $clog2(GATE_CYCLES / 2 + 1) + 1;
   localparam int RW    = EW + 1;
   localparam int AW    = OUT_W + AVG_LOG2;
   localparam int WW    = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;

   localparam logic [GW-1:0] GATE_LAST = GW'(GATE_CYCLES - 1);
   localparam logic [EW-1:0] EDGE_MAX  = '1;
   localparam logic [WW-1:0] WIN_LAST  = WW'((1 << AVG_LOG2) - 1);
   localparam logic [63:0]   SCALE_W   = 64'(SCALE);
   localparam logic [63:0]   MIN_W     = 64'(MIN_EDGES);
   localparam logic [63:0]   OUT_MAX   = (64'd1 << OUT_W) - 64'd1;

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic                   prev_q, prev_d;
   logic [GW-1:0]          gate_q, gate_d;
   logic [EW-1:0]          edge_cnt_q, edge_cnt_d;
   logic [RW-1:0]          raw_q, raw_d;
   logic                   v1_q, v1_d;
   logic [AW-1:0]          acc_q, acc_d;
   logic                   acc_sil_q, acc_sil_d;
   logic                   acc_ovf_q, acc_ovf_d;
   logic [WW-1:0]          win_q, win_d;
   logic [OUT_W-1:0]       res_q, res_d;
   logic                   res_sil_q, res_sil_d;
   logic                   res_ovf_q, res_ovf_d;
   logic                   v2_q, v2_d;
   logic [OUT_W-1:0]       freq_q, freq_d;
   logic                   valid_q, valid_d;
   logic                   silent_q, silent_d;
   logic                   overflow_q, overflow_d;

   logic                   sig_s;
   logic                   edge_det;
   logic                   terminal;
   logic [63:0]            prod;
   logic [OUT_W-1:0]       scaled;
   logic                   sil_w;
   logic                   ovf_w;
   logic [AW-1:0]          sum_c;
   logic                   last_win;

   assign sig_s    = sync_q[SYNC_STAGES-1];
   assign edge_det = sig_s & ~prev_q;
   assign terminal = enable && (gate_q == GATE_LAST);

   // Synchroniser, edge history, gate counter and saturating edge counter
   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], signal};
      prev_d = sig_s;
      gate_d = '0;
      edge_cnt_d = '0;
      raw_d = raw_q;
      v1_d = terminal;
      if (enable && !terminal) begin
         gate_d = gate_q + GW'(1);
         edge_cnt_d = edge_cnt_q;
         if (edge_det && (edge_cnt_q != EDGE_MAX)) begin
            edge_cnt_d = edge_cnt_q + EW'(1);
         end
      end
      if (terminal) begin
         // the edge seen on the terminal cycle belongs to the closing window
         raw_d = {1'b0, edge_cnt_q} + RW'(edge_det);
      end
   end

   // Stage 1: scale the raw count to Hz, clamp it and flag silence
   always_comb begin
      prod = 64'(raw_q) * SCALE_W;
      scaled = '0;
      sil_w = 1'b0;
      ovf_w = 1'b0;
      if (64'(raw_q) < MIN_W) begin
         sil_w = 1'b1;
      end else if (prod > OUT_MAX) begin
         scaled = '1;
         ovf_w = 1'b1;
      end else begin
         scaled = prod[OUT_W-1:0];
      end
   end

   // Stage 1: fold the window into the average group; the group result is latched
   // from the pre-clear accumulator so a result in flight survives enable dropping
   always_comb begin
      sum_c = acc_q + AW'(scaled);
      last_win = (win_q == WIN_LAST);
      acc_d = acc_q;
      acc_sil_d = acc_sil_q;
      acc_ovf_d = acc_ovf_q;
      win_d = win_q;
      res_d = res_q;
      res_sil_d = res_sil_q;
      res_ovf_d = res_ovf_q;
      v2_d = v1_q && last_win;
      if (v1_q && last_win) begin
         res_d = OUT_W'(sum_c >> AVG_LOG2);
         res_sil_d = acc_sil_q | sil_w;
         res_ovf_d = acc_ovf_q | ovf_w;
      end
      if (!enable) begin
         acc_d = '0;
         acc_sil_d = 1'b0;
         acc_ovf_d = 1'b0;
         win_d = '0;
      end else if (v1_q) begin
         if (last_win) begin
            acc_d = '0;
            acc_sil_d = 1'b0;
            acc_ovf_d = 1'b0;
            win_d = '0;
         end else begin
            acc_d = sum_c;
            acc_sil_d = acc_sil_q | sil_w;
            acc_ovf_d = acc_ovf_q | ovf_w;
            win_d = win_q + WW'(1);
         end
      end
   end

   // Stage 2: publish the result with a one-cycle strobe, otherwise hold outputs
   always_comb begin
      freq_d = freq_q;
      silent_d = silent_q;
      overflow_d = overflow_q;
      valid_d = v2_q;
      if (v2_q) begin
         freq_d = res_q;
         silent_d = res_sil_q;
         overflow_d = res_ovf_q;
      end
   end

   // All state registers, cleared immediately by reset
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_q     <= '0;
         prev_q     <= 1'b0;
         gate_q     <= '0;
         edge_cnt_q <= '0;
         raw_q      <= '0;
         v1_q       <= 1'b0;
         acc_q      <= '0;
         acc_sil_q  <= 1'b0;
         acc_ovf_q  <= 1'b0;
         win_q      <= '0;
         res_q      <= '0;
         res_sil_q  <= 1'b0;
         res_ovf_q  <= 1'b0;
         v2_q       <= 1'b0;
         freq_q     <= '0;
         valid_q    <= 1'b0;
         silent_q   <= 1'b1;
         overflow_q <= 1'b0;
      end else begin
         sync_q     <= sync_d;
         prev_q     <= prev_d;
         gate_q     <= gate_d;
         edge_cnt_q <= edge_cnt_d;
         raw_q      <= raw_d;
         v1_q       <= v1_d;
         acc_q      <= acc_d;
         acc_sil_q  <= acc_sil_d;
         acc_ovf_q  <= acc_ovf_d;
         win_q      <= win_d;
         res_q      <= res_d;
         res_sil_q  <= res_sil_d;
         res_ovf_q  <= res_ovf_d;
         v2_q       <= v2_d;
         freq_q     <= freq_d;
         valid_q    <= valid_d;
         silent_q   <= silent_d;
         overflow_q <= overflow_d;
      end
   end

   assign freq       = freq_q;
   assign freq_valid = valid_q;
   assign silent     = silent_q;
   assign overflow   = overflow_q;

endmodule

// File: tb/tb_mic_freq_meter.sv
// tb/tb_mic_freq_meter.sv - randomized model-checked bench for mic_freq_meter
module tb_mic_freq_meter;

   localparam int G    = 100;
   localparam int S    = 2;
   localparam int SC   = 10;
   localparam int MAXC = 16384;

   logic clk = 1'b0;
   logic reset, enable, signal;
   logic [7:0] fa, fc;
   logic [5:0] fb;
   logic va, sa, oa, vb, sb, ob, vc, sc_o, oc;

   always #5 clk = ~clk;

   mic_freq_meter #(.CLK_FREQ(1000), .GATE_CYCLES(G), .OUT_W(8), .SYNC_STAGES(S),
                    .AVG_LOG2(0), .MIN_EDGES(2)) dut_a (
      .clk(clk), .reset(reset), .enable(enable), .signal(signal),
      .freq(fa), .freq_valid(va), .silent(sa), .overflow(oa));

   mic_freq_meter #(.CLK_FREQ(1000), .GATE_CYCLES(G), .OUT_W(6), .SYNC_STAGES(S),
                    .AVG_LOG2(0), .MIN_EDGES(2)) dut_b (
      .clk(clk), .reset(reset), .enable(enable), .signal(signal),
      .freq(fb), .freq_valid(vb), .silent(sb), .overflow(ob));

   mic_freq_meter #(.CLK_FREQ(1000), .GATE_CYCLES(G), .OUT_W(8), .SYNC_STAGES(S),
                    .AVG_LOG2(2), .MIN_EDGES(2)) dut_c (
      .clk(clk), .reset(reset), .enable(enable), .signal(signal),
      .freq(fc), .freq_valid(vc), .silent(sc_o), .overflow(oc));

   int n_chk = 0;
   int n_fail = 0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // reference model state
   bit sig_rec[MAXC];
   int cyc = 0;
   int floor_c = 0;
   bit running = 0;
   int start_c = 0;
   int due[3]    = '{-1, -1, -1};
   int e_freq[3] = '{0, 0, 0};
   int e_sil[3]  = '{1, 1, 1};
   int e_ovf[3]  = '{0, 0, 0};
   int h_freq[3] = '{0, 0, 0};
   int h_sil[3]  = '{1, 1, 1};
   int h_ovf[3]  = '{0, 0, 0};
   int c_acc = 0, c_sil = 0, c_ovf = 0;
   int spurious = 0, hold_err = 0;

   function automatic int eff(int i);
      if (i < 0 || i < floor_c) return 0;
      return int'(sig_rec[i]);
   endfunction

   // rising edges seen by the synchronised input over the window ending at edge index last
   function automatic int window_edges(int last);
      int n = 0;
      for (int j = last - G + 1; j <= last; j++)
         if (eff(j - S) == 1 && eff(j - S - 1) == 0) n++;
      return n;
   endfunction

   function automatic logic [31:0] o_freq(int d);
      case (d)
         0: return 32'(fa);
         1: return 32'(fb);
         default: return 32'(fc);
      endcase
   endfunction
   function automatic logic o_valid(int d);
      case (d) 0: return va; 1: return vb; default: return vc; endcase
   endfunction
   function automatic logic o_sil(int d);
      case (d) 0: return sa; 1: return sb; default: return sc_o; endcase
   endfunction
   function automatic logic o_ovf(int d);
      case (d) 0: return oa; 1: return ob; default: return oc; endcase
   endfunction

   // model update at each active edge, then compare the DUT just after it
   always @(posedge clk) begin
      int c, raw, sv, sl, ov, lim;
      c = cyc;
      sig_rec[c] = signal;
      if (reset) begin
         running = 0;
         floor_c = c + 1;
         c_acc = 0; c_sil = 0; c_ovf = 0;
         for (int d = 0; d < 3; d++) begin
            due[d] = -1; h_freq[d] = 0; h_sil[d] = 1; h_ovf[d] = 0;
         end
      end else if (enable) begin
         if (!running) begin
            running = 1; start_c = c;
            c_acc = 0; c_sil = 0; c_ovf = 0;
         end
         if ((c - start_c) % G == G - 1) begin
            raw = window_edges(c);
            for (int d = 0; d < 3; d++) begin
               lim = (d == 1) ? 63 : 255;
               sv = raw * SC; sl = 0; ov = 0;
               if (raw < 2) begin sv = 0; sl = 1; end
               else if (sv > lim) begin sv = lim; ov = 1; end
               if (d < 2) begin
                  due[d] = c + 2; e_freq[d] = sv; e_sil[d] = sl; e_ovf[d] = ov;
               end else begin
                  c_acc += sv; c_sil |= sl; c_ovf |= ov;
                  if (((c - start_c) / G) % 4 == 3) begin
                     due[2] = c + 2; e_freq[2] = c_acc / 4; e_sil[2] = c_sil; e_ovf[2] = c_ovf;
                     c_acc = 0; c_sil = 0; c_ovf = 0;
                  end
               end
            end
         end
      end else begin
         running = 0;
      end
      #1;
      for (int d = 0; d < 3; d++) begin
         if (due[d] == c) begin
            check_eq($sformatf("valid_d%0d_c%0d", d, c), 32'(o_valid(d)), 32'd1);
            check_eq($sformatf("freq_d%0d_c%0d", d, c), o_freq(d), 32'(e_freq[d]));
            check_eq($sformatf("silent_d%0d_c%0d", d, c), 32'(o_sil(d)), 32'(e_sil[d]));
            check_eq($sformatf("ovf_d%0d_c%0d", d, c), 32'(o_ovf(d)), 32'(e_ovf[d]));
            h_freq[d] = e_freq[d]; h_sil[d] = e_sil[d]; h_ovf[d] = e_ovf[d];
            due[d] = -1;
         end else begin
            if (o_valid(d) !== 1'b0) spurious++;
            if (o_freq(d) !== 32'(h_freq[d]) || o_sil(d) !== h_sil[d] || o_ovf(d) !== h_ovf[d])
               hold_err++;
         end
      end
      cyc++;
   end

   int ph = 0;

   task automatic drive(input logic s, input logic e);
      @(negedge clk);
      signal = s;
      enable = e;
   endtask

   task automatic square(input int n, input int hi, input int lo, input logic e);
      for (int i = 0; i < n; i++) begin
         if (hi == 0) begin
            drive(1'b0, e); ph = 0;
         end else begin
            drive(logic'(ph < hi), e);
            ph++;
            if (ph >= hi + lo) ph = 0;
         end
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check_eq({tag, "_freq_a"}, 32'(fa), 32'd0);
      check_eq({tag, "_valid_a"}, 32'(va), 32'd0);
      check_eq({tag, "_silent_a"}, 32'(sa), 32'd1);
      check_eq({tag, "_ovf_a"}, 32'(oa), 32'd0);
      check_eq({tag, "_freq_c"}, 32'(fc), 32'd0);
      check_eq({tag, "_silent_c"}, 32'(sc_o), 32'd1);
   endtask

   task automatic pulse_run(input int shift);
      for (int i = 0; i < 200; i++) begin
         drive(logic'((i inside {10, 11, 30, 31, 50, 51, 70, 71}) ||
                      i == 97 + shift || i == 98 + shift), 1'b1);
      end
   endtask

   initial begin
      reset = 1'b1; enable = 1'b0; signal = 1'b0;
      repeat (3) @(negedge clk);
      check_reset_outputs("por");
      reset = 1'b0;
      square(10, 0, 0, 1'b0);

      // steady 100 Hz
      ph = 0; square(400, 5, 5, 1'b1);
      square(5, 0, 0, 1'b0);
      check_eq("plan1_freq", 32'(fa), 32'd100);
      check_eq("plan1_silent", 32'(sa), 32'd0);

      // silence, then a single edge in a window
      square(100, 0, 0, 1'b1);
      for (int i = 0; i < 100; i++) drive(logic'(i == 20), 1'b1);
      square(205, 0, 0, 1'b1);
      square(5, 0, 0, 1'b0);

      // 250 Hz: fits 8 bits, saturates 6 bits
      ph = 0; square(400, 2, 2, 1'b1);
      square(5, 0, 0, 1'b0);
      check_eq("plan3_freq_b", 32'(fb), 32'd63);
      check_eq("plan3_ovf_b", 32'(ob), 32'd1);

      // averaged group 100,100,50,50
      ph = 0; square(100, 5, 5, 1'b1);
      ph = 0; square(100, 5, 5, 1'b1);
      ph = 0; square(100, 10, 10, 1'b1);
      ph = 0; square(100, 10, 10, 1'b1);
      square(5, 0, 0, 1'b0);
      check_eq("plan4_avg", 32'(fc), 32'd75);

      // edge on the terminal cycle, then the same edge one cycle later
      pulse_run(0);
      square(5, 0, 0, 1'b0);
      pulse_run(1);
      square(5, 0, 0, 1'b0);

      // reset mid-window after five edges
      ph = 0; square(50, 5, 5, 1'b1);
      @(negedge clk);
      reset = 1'b1;
      #1;
      check_reset_outputs("mid_reset");
      square(2, 5, 5, 1'b1);
      @(negedge clk);
      reset = 1'b0;
      square(400, 5, 5, 1'b1);

      // enable dropped mid-window
      ph = 0; square(150, 4, 4, 1'b1);
      square(60, 3, 3, 1'b0);

      // randomized segments
      for (int k = 0; k < 14; k++) begin
         int hi, lo, n;
         hi = $urandom_range(2, 12);
         lo = $urandom_range(2, 12);
         n = $urandom_range(40, 320);
         if ($urandom_range(0, 9) == 0) hi = 0;
         square(n, hi, lo, logic'($urandom_range(0, 6) != 0));
         if ($urandom_range(0, 7) == 0) begin
            @(negedge clk);
            reset = 1'b1;
            square(2, 0, 0, 1'b1);
            @(negedge clk);
            reset = 1'b0;
         end
      end

      square(10, 0, 0, 1'b0);
      check_eq("spurious_strobes", 32'(spurious), 32'd0);
      check_eq("hold_errors", 32'(hold_err), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
